// File: rtl/dart_pkg.sv
// Shared types and constants for the DART UART port blocks.
package dart_pkg;

    localparam int unsigned DART_WORD_W  = 16;
    localparam int unsigned DART_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_NEXT = 2'd2
    } dart_state_e;

endpackage

// File: rtl/dart_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NUM_REQ.
module dart_rr_pick
    import dart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [2:0]         winner,
    output logic               any
);

    logic [DART_MAX_REQ-1:0] req_pad;
    int unsigned             idx;

    always_comb begin
        req_pad              = '0;
        req_pad[NUM_REQ-1:0] = req;
        winner               = '0;
        any                  = 1'b0;
        idx                  = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!any && req_pad[3'(idx)]) begin
                winner = 3'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dart_tx_arbiter.sv
// Round-robin burst arbiter sharing the DART UART transmit channel between NUM_REQ requesters.
module dart_tx_arbiter
    import dart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = DART_WORD_W,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ack,
    output logic [2:0]               grant_id,
    output logic                     busy,
    output logic                     arb_error
);

    dart_state_e          state_q, state_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [2:0]           grant_q, grant_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 valid_q, busy_q;
    logic                 err_q, err_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           pick, sel;
    logic                 pick_any, capture, timed_out;

    logic [DART_MAX_REQ-1:0] valid_pad, last_pad;
    logic [WIDTH-1:0]        word_arr [DART_MAX_REQ];

    dart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .winner (pick),
        .any    (pick_any)
    );

    // Pad per-requester inputs to the maximum width so a 3-bit index is always in range.
    always_comb begin
        valid_pad              = '0;
        last_pad               = '0;
        valid_pad[NUM_REQ-1:0] = req_valid;
        last_pad[NUM_REQ-1:0]  = req_last;
        for (int unsigned i = 0; i < DART_MAX_REQ; i++) word_arr[i] = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) word_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    assign sel       = (state_q == IDLE) ? pick : grant_q;
    assign timed_out = ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ack_d   = '0;
        capture = 1'b0;

        if (tx_ack && !valid_q) err_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (enable && pick_any) capture = 1'b1;
            end
            SEND: begin
                if (tx_ack) begin
                    if (last_q) begin
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_NEXT;
                    end
                end
            end
            WAIT_NEXT: begin
                if (valid_pad[grant_q]) begin
                    capture = 1'b1;
                end else if (timed_out) begin
                    // Abandon the burst; the owner loses its turn like a completed burst.
                    err_d   = 1'b1;
                    ptr_d   = grant_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d = SEND;
            grant_d = sel;
            data_d  = word_arr[sel];
            last_d  = last_pad[sel];
            for (int unsigned i = 0; i < NUM_REQ; i++) ack_d[i] = (sel == 3'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 3'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            valid_q <= (state_d == SEND);
            busy_q  <= (state_d != IDLE);
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ack   = ack_q;
    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign arb_error = err_q;

endmodule

// File: tb/tb_dart_tx_arbiter.sv
// Directed bench for dart_tx_arbiter with a transaction-level reference model.
module tb_dart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TO   = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_last = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0] req_ack;
    logic [W-1:0]    tx_data;
    logic            tx_valid;
    logic            tx_ack = 1'b0;
    logic [2:0]      grant_id;
    logic            busy;
    logic            arb_error;

    dart_tx_arbiter #(
        .NUM_REQ (NREQ),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ack    (tx_ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .arb_error (arb_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Per-requester word queues: {last, data}
    logic [16:0] rq [NREQ][$];
    logic        auto_ack = 1'b1;
    logic        force_ack = 1'b0;
    int          ack_delay = 1;
    int          ack_cnt = 0;

    // Model state
    logic        m_tx_valid, m_last, m_err, m_open, m_busy;
    logic [15:0] m_data;
    logic [3:0]  m_ack;
    int          m_grant, m_prev, m_gap;
    int          dut_grants[$], m_grants[$];
    logic [15:0] dut_words[$], m_words[$];
    logic        prev_valid = 1'b0;
    logic [15:0] prev_data = '0;
    logic        s_rst, s_en, s_ack;
    logic [3:0]  s_v, s_l;
    logic [63:0] s_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic take(input int w);
        m_data     = s_d[w*16 +: 16];
        m_last     = s_l[w];
        m_grant    = w;
        m_ack[w]   = 1'b1;
        m_tx_valid = 1'b1;
        m_grants.push_back(w);
    endtask

    task automatic model_step();
        int c;
        m_ack = '0;
        if (s_rst) begin
            m_tx_valid = 0; m_last = 0; m_err = 0; m_open = 0;
            m_data = '0; m_grant = 0; m_prev = NREQ - 1; m_gap = 0;
        end else begin
            if (s_ack && !m_tx_valid) m_err = 1'b1;
            if (m_tx_valid) begin
                if (s_ack) begin
                    m_words.push_back(m_data);
                    m_tx_valid = 1'b0;
                    if (m_last) begin
                        m_open = 1'b0;
                        m_prev = m_grant;
                    end else begin
                        m_open = 1'b1;
                        m_gap  = 0;
                    end
                end
            end else if (m_open) begin
                if (s_v[m_grant]) begin
                    take(m_grant);
                end else begin
                    m_gap++;
                    if (m_gap == TO) begin
                        m_err  = 1'b1;
                        m_open = 1'b0;
                        m_prev = m_grant;
                    end
                end
            end else if (s_en && s_v != 0) begin
                c = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_prev + k) % NREQ;
                    if (s_v[c]) break;
                end
                take(c);
            end
        end
        m_busy = m_tx_valid || m_open;
    endtask

    // Compare process: model advances on each edge, DUT checked 1 time unit later.
    initial begin
        forever begin
            @(posedge clock);
            s_rst = reset; s_en = enable; s_ack = tx_ack;
            s_v = req_valid; s_l = req_last; s_d = req_data;
            if (prev_valid && s_ack && !s_rst) dut_words.push_back(prev_data);
            model_step();
            #1;
            chk("req_ack", 32'(req_ack), 32'(m_ack));
            chk("tx_valid", 32'(tx_valid), 32'(m_tx_valid));
            if (m_tx_valid) chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("grant_id", 32'(grant_id), 32'(m_grant));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("arb_error", 32'(arb_error), 32'(m_err));
            if (req_ack != 0) dut_grants.push_back(int'(grant_id));
            prev_valid = tx_valid;
            prev_data  = tx_data;
        end
    end

    // Requesters and UART sink, driven away from the active edge.
    always @(negedge clock) begin
        if (tx_ack) begin
            tx_ack = 1'b0;
        end else if (force_ack) begin
            tx_ack    = 1'b1;
            force_ack = 1'b0;
        end else if (auto_ack && tx_valid) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                tx_ack  = 1'b1;
                ack_cnt = 0;
            end
        end else begin
            ack_cnt = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                req_valid[i] = 1'b0;
            end else if (req_ack[i]) begin
                if (rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i] = 1'b0;
            end else if (!req_valid[i] && rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                {req_last[i], req_data[i*16 +: 16]} = rq[i][0];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic clear_logs();
        dut_grants.delete(); m_grants.delete();
        dut_words.delete();  m_words.delete();
    endtask

    task automatic do_reset();
        foreach (rq[i]) rq[i].delete();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        clear_logs();
    endtask

    function automatic int pending();
        int n = 0;
        foreach (rq[i]) n += rq[i].size();
        return n;
    endfunction

    task automatic wait_quiet(input string name, input int max);
        int quiet = 0;
        logic ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            tick(1);
            if (pending() == 0 && req_valid == 0 && !busy && !tx_valid && !tx_ack) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, " drained"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_grants(input string name, input int cnt, input int max);
        logic ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            if (dut_grants.size() >= cnt) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk({name, " grant seen"}, 32'(ok), 32'd1);
    endtask

    task automatic chk_grants(input string name, input int exp[$]);
        chk({name, " dut grant count"}, 32'(dut_grants.size()), 32'(exp.size()));
        chk({name, " model grant count"}, 32'(m_grants.size()), 32'(exp.size()));
        foreach (exp[k]) begin
            if (k < dut_grants.size()) chk({name, " dut grant"}, 32'(dut_grants[k]), 32'(exp[k]));
            if (k < m_grants.size()) chk({name, " model grant"}, 32'(m_grants[k]), 32'(exp[k]));
        end
    endtask

    task automatic chk_words(input string name, input logic [15:0] exp[$]);
        chk({name, " dut word count"}, 32'(dut_words.size()), 32'(exp.size()));
        chk({name, " model word count"}, 32'(m_words.size()), 32'(exp.size()));
        foreach (exp[k]) begin
            if (k < dut_words.size()) chk({name, " dut word"}, 32'(dut_words[k]), 32'(exp[k]));
            if (k < m_words.size()) chk({name, " model word"}, 32'(m_words[k]), 32'(exp[k]));
        end
    endtask

    initial begin
        int          eg[$];
        logic [15:0] ew[$];
        logic        ok;

        do_reset();
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset req_ack", 32'(req_ack), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset arb_error", 32'(arb_error), 32'd0);

        // Single word from requester 2
        rq[2].push_back({1'b1, 16'hA5A5});
        wait_quiet("single", 50);
        eg = '{2};
        chk_grants("single", eg);
        ew = '{16'hA5A5};
        chk_words("single", ew);
        chk("single grant_id", 32'(grant_id), 32'd2);

        // Fairness across all four requesters
        do_reset();
        rq[0].push_back({1'b1, 16'h0001});
        rq[0].push_back({1'b1, 16'h0005});
        rq[1].push_back({1'b1, 16'h0002});
        rq[2].push_back({1'b1, 16'h0003});
        rq[3].push_back({1'b1, 16'h0004});
        wait_quiet("fair", 100);
        eg = '{0, 1, 2, 3, 0};
        chk_grants("fair", eg);

        // Burst lock: requester 0 waits behind requester 1's three-word burst
        do_reset();
        ack_delay = 3;
        rq[1].push_back({1'b0, 16'h1111});
        rq[1].push_back({1'b0, 16'h2222});
        rq[1].push_back({1'b1, 16'h3333});
        wait_grants("burst", 1, 20);
        rq[0].push_back({1'b1, 16'h0B0B});
        wait_quiet("burst", 100);
        eg = '{1, 1, 1, 0};
        chk_grants("burst", eg);
        ew = '{16'h1111, 16'h2222, 16'h3333, 16'h0B0B};
        chk_words("burst", ew);
        ack_delay = 1;

        // Timeout: requester 3 stalls mid-burst
        do_reset();
        rq[3].push_back({1'b0, 16'h3C3C});
        wait_grants("timeout", 1, 20);
        rq[0].push_back({1'b1, 16'h0A0A});
        rq[1].push_back({1'b1, 16'h1A1A});
        wait_quiet("timeout", 100);
        chk("timeout arb_error", 32'(arb_error), 32'd1);
        eg = '{3, 0, 1};
        chk_grants("timeout", eg);

        // Spurious ack in IDLE, then enable gating
        do_reset();
        auto_ack  = 1'b0;
        force_ack = 1'b1;
        tick(3);
        chk("spurious arb_error", 32'(arb_error), 32'd1);
        chk("spurious tx_valid", 32'(tx_valid), 32'd0);
        auto_ack = 1'b1;
        enable   = 1'b0;
        rq[1].push_back({1'b1, 16'h5151});
        tick(6);
        chk("enable low grants", 32'(dut_grants.size()), 32'd0);
        enable = 1'b1;
        wait_quiet("enable", 50);
        eg = '{1};
        chk_grants("enable", eg);

        // Reset while in WAIT_NEXT
        do_reset();
        rq[2].push_back({1'b0, 16'h2B2B});
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick(1);
            if (dut_grants.size() == 1 && busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midburst reached wait", 32'(ok), 32'd1);
        tick(2);
        reset = 1'b1;
        foreach (rq[i]) rq[i].delete();
        tick(1);
        chk("midburst tx_valid", 32'(tx_valid), 32'd0);
        chk("midburst busy", 32'(busy), 32'd0);
        chk("midburst grant_id", 32'(grant_id), 32'd0);
        chk("midburst req_ack", 32'(req_ack), 32'd0);
        chk("midburst arb_error", 32'(arb_error), 32'd0);
        reset = 1'b0;
        clear_logs();
        rq[0].push_back({1'b1, 16'h0D0D});
        rq[2].push_back({1'b1, 16'h2C2C});
        wait_quiet("midburst", 60);
        eg = '{0, 2};
        chk_grants("midburst", eg);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
